si570_i2c_responder: RTL and testbench

Synthesizable I2C target that emulates the Si570 programmable oscillator's control register file (registers 7–12, 135, 137). It is the bus-side counterpart of the on-board Si570 configuration master. It serves as a drop-in oscillator model in simulation, and as a soft Si570 on boards whose clock synthesizer is driven from decoded HS_DIV/N1/RFREQ values. Sits directly on the shared open-drain SDA/SCL pins, with 7-bit addressing and standard/fast-mode timing oversampled by `clk`.

---
 rtl/si570_pkg.sv | 40 ++++
 rtl/si570_i2c_responder_line_cond.sv | 75 +++++++
 rtl/si570_i2c_responder.sv | 179 +++++++++++++++++
 tb/tb_si570_i2c_responder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/si570_pkg.sv
// Shared constants for the Si570 register-file I2C responder: FSM state codes,
// register addresses, control bit positions, HS_DIV codes and a majority helper.
package si570_pkg;

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StAddr     = 4'd1;
  localparam logic [3:0] StAddrAck  = 4'd2;
  localparam logic [3:0] StPtr      = 4'd3;
  localparam logic [3:0] StPtrAck   = 4'd4;
  localparam logic [3:0] StWdata    = 4'd5;
  localparam logic [3:0] StWdataAck = 4'd6;
  localparam logic [3:0] StRdata    = 4'd7;
  localparam logic [3:0] StRdataAck = 4'd8;

  localparam logic [7:0] RegHsN1   = 8'd7;
  localparam logic [7:0] RegLast   = 8'd12;
  localparam logic [7:0] RegRecall = 8'd135;
  localparam logic [7:0] RegFreeze = 8'd137;

  localparam int RecallBit  = 0;
  localparam int NewFreqBit = 6;
  localparam int FreezeBit  = 4;

  // HS_DIV field encodings (divide ratio in the name); codes 3'd4 and 3'd6 are unused.
  localparam logic [2:0] HsDiv4  = 3'd0;
  localparam logic [2:0] HsDiv5  = 3'd1;
  localparam logic [2:0] HsDiv6  = 3'd2;
  localparam logic [2:0] HsDiv7  = 3'd3;
  localparam logic [2:0] HsDiv9  = 3'd5;
  localparam logic [2:0] HsDiv11 = 3'd7;

  function automatic logic is_freq_reg(input logic [7:0] addr);
    return (addr >= RegHsN1) && (addr <= RegLast);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/si570_i2c_responder_line_cond.sv
// i2c_line_cond: synchronizes SCL/SDA, optionally majority-filters them
// (SI570_RESP_GLITCH_FILTER_EN) and registers SCL edge and START/STOP events.
module i2c_line_cond
  import si570_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f;
  logic       scl_q, sda_q;

  // Idle bus is high, so the pipeline resets to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef SI570_RESP_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_f    <= maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
      sda_f    <= maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  // sda is registered alongside the events so the FSM sees the level that
  // belongs to the same sample as scl_rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      sda      <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      scl_q    <= scl_f;
      sda_q    <= sda_f;
      sda      <= sda_f;
      scl_rise <= scl_f & ~scl_q;
      scl_fall <= ~scl_f & scl_q;
      start    <= scl_f & scl_q & sda_q & ~sda_f;
      stop     <= scl_f & scl_q & ~sda_q & sda_f;
    end
  end

endmodule

// File: rtl/si570_i2c_responder.sv
// I2C target emulating the Si570 control registers 7..12, 135 and 137.
// Optional input glitch filter: define SI570_RESP_GLITCH_FILTER_EN.
module si570_i2c_responder
  import si570_pkg::*;
#(
  parameter logic [6:0]  I2CAddress  = 7'h55,
  parameter logic [47:0] FactoryRegs = 48'h01_C2_BC_01_1E_B8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_t,
  output logic [2:0]  hs_div,
  output logic [6:0]  n1,
  output logic [37:0] rfreq,
  output logic        freeze_dco,
  output logic        new_freq,
  output logic        busy
);

  logic       sda_lvl, scl_rise, scl_fall, start, stop;
  logic [3:0] state, bit_cnt;
  logic [7:0] shreg, ptr, rx_byte, rd_byte;
  logic [2:0] reg_idx;
  logic       rd_mode, ack_drv;
  logic [0:5][7:0] regs;

  i2c_line_cond u_line_cond (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda_lvl),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign sda_o   = 1'b0;
  assign rx_byte = {shreg[6:0], sda_lvl};
  // Addresses 7..12 are 7,0,1,2,3,4 mod 8, so +1 maps them onto 0..5.
  assign reg_idx = ptr[2:0] + 3'd1;

  assign hs_div = regs[0][7:5];
  assign n1     = {regs[0][4:0], regs[1][7:6]};
  assign rfreq  = {regs[1][5:0], regs[2], regs[3], regs[4], regs[5]};

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rd_byte = 8'h00;
    if (is_freq_reg(ptr)) rd_byte = regs[reg_idx];
    else if (ptr == RegFreeze) rd_byte[FreezeBit] = freeze_dco;
  end

  // NOTE: the register file is reset on purpose: reset must restore factory contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      ptr        <= 8'h00;
      rd_mode    <= 1'b0;
      ack_drv    <= 1'b0;
      sda_t      <= 1'b1;
      busy       <= 1'b0;
      regs       <= FactoryRegs;
      freeze_dco <= 1'b0;
      new_freq   <= 1'b0;
    end else begin
      new_freq <= 1'b0;
      if (start) begin
        state   <= StAddr;
        bit_cnt <= 4'd0;
        ack_drv <= 1'b0;
        sda_t   <= 1'b1;
        busy    <= 1'b1;
      end else if (stop) begin
        state   <= StIdle;
        ack_drv <= 1'b0;
        sda_t   <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state)
          StAddr, StPtr, StWdata: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (state == StAddr) begin
                  if (shreg[6:0] == I2CAddress) begin
                    rd_mode <= sda_lvl;
                    state   <= StAddrAck;
                  end else begin
                    state <= StIdle;
                  end
                end else if (state == StPtr) begin
                  ptr   <= rx_byte;
                  state <= StPtrAck;
                end else begin
                  state <= StWdataAck;
                  if (is_freq_reg(ptr)) begin
                    regs[reg_idx] <= rx_byte;
                  end else if (ptr == RegRecall) begin
                    if (rx_byte[RecallBit]) regs <= FactoryRegs;
                    new_freq <= rx_byte[NewFreqBit];
                  end else if (ptr == RegFreeze) begin
                    freeze_dco <= rx_byte[FreezeBit];
                  end
                end
              end
            end
          end
          StAddrAck, StPtrAck, StWdataAck: begin
            // First fall after bit 8 pulls SDA low, the next one releases it.
            if (scl_fall) begin
              if (!ack_drv) begin
                sda_t   <= 1'b0;
                ack_drv <= 1'b1;
              end else begin
                ack_drv <= 1'b0;
                sda_t   <= 1'b1;
                if (state == StAddrAck) begin
                  if (rd_mode) begin
                    state <= StRdata;
                    shreg <= rd_byte;
                    sda_t <= rd_byte[7];
                  end else begin
                    state <= StPtr;
                  end
                end else if (state == StPtrAck) begin
                  state <= StWdata;
                end else begin
                  ptr   <= ptr + 8'd1;
                  state <= StWdata;
                end
              end
            end
          end
          StRdata: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_t   <= 1'b1;
                bit_cnt <= 4'd0;
                state   <= StRdataAck;
              end else begin
                shreg <= {shreg[6:0], 1'b0};
                sda_t <= shreg[6];
              end
            end
          end
          StRdataAck: begin
            if (scl_rise) begin
              if (!sda_lvl) begin
                ptr     <= ptr + 8'd1;
                ack_drv <= 1'b1;
              end else begin
                state <= StIdle;
              end
            end
            if (scl_fall && ack_drv) begin
              ack_drv <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= StRdata;
              shreg   <= rd_byte;
              sda_t   <= rd_byte[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_si570_i2c_responder.sv
// Bit-banged I2C master with expected-value scoreboard for si570_i2c_responder.
module tb_si570_i2c_responder;

  typedef struct {
    string       name;
    logic [63:0] v;
  } item_t;
  typedef logic [7:0] bytes_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  wire         sda_line;
  logic        sda_o, sda_t, freeze_dco, new_freq, busy;
  logic [2:0]  hs_div;
  logic [6:0]  n1;
  logic [37:0] rfreq;

  item_t  exp_q[$];
  item_t  act_q[$];
  int     checks = 0;
  int     errors = 0;
  int     nf_cnt = 0;
  logic   watch = 1'b0;
  logic   saw_low = 1'b0;
  bytes_t data;

  localparam logic [37:0] FactRfreq = 38'h2_BC01_1EB8;

  si570_i2c_responder dut (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_o      (sda_o),
    .sda_t      (sda_t),
    .hs_div     (hs_div),
    .n1         (n1),
    .rfreq      (rfreq),
    .freeze_dco (freeze_dco),
    .new_freq   (new_freq),
    .busy       (busy)
  );

  assign sda_line = sda_m & (sda_t | sda_o);

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (new_freq) nf_cnt <= nf_cnt + 1;
    if (watch && !sda_t) saw_low <= 1'b1;
  end

  // Monitor: pops one expectation per observed DUT output.
  initial begin
    item_t a, e;
    forever begin
      @(negedge clk);
      while (act_q.size() > 0) begin
        a = act_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s got %0h but no value was expected", a.name, a.v);
        end else begin
          e = exp_q.pop_front();
          if (a.v !== e.v || a.name != e.name) begin
            errors++;
            $display("FAIL %s got %0h (%s) want %0h", e.name, a.v, a.name, e.v);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic expect_v(input string n, input logic [63:0] v);
    item_t it;
    it.name = n;
    it.v    = v;
    exp_q.push_back(it);
  endtask

  task automatic observe(input string n, input logic [63:0] v);
    item_t it;
    it.name = n;
    it.v    = v;
    act_q.push_back(it);
  endtask

  task automatic qw;
    #100;
  endtask

  task automatic bus_start;
    sda_m = 1'b1; qw;
    scl_m = 1'b1; qw;
    sda_m = 1'b0; qw;
    scl_m = 1'b0; qw;
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; qw;
    scl_m = 1'b1; qw;
    sda_m = 1'b1; qw; qw;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    qw;
    scl_m = 1'b1; qw; qw;
    scl_m = 1'b0; qw;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; qw;
    scl_m = 1'b1; qw;
    b = sda_line; qw;
    scl_m = 1'b0; qw;
  endtask

  task automatic write_byte(input logic [7:0] d, input string n, input logic exp_ack);
    logic a;
    expect_v(n, 64'(exp_ack));
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    observe(n, 64'(a));
  endtask

  task automatic read_byte(input string n, input logic [7:0] exp, input logic ack);
    logic [7:0] v;
    logic       b;
    expect_v(n, 64'(exp));
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(~ack);
    observe(n, 64'(v));
  endtask

  task automatic wr_regs(input logic [7:0] p, input bytes_t d);
    bus_start;
    write_byte(8'hAA, "wr_hdr_ack", 1'b0);
    write_byte(p, "wr_ptr_ack", 1'b0);
    for (int i = 0; i < d.size(); i++) write_byte(d[i], "wr_data_ack", 1'b0);
    bus_stop;
  endtask

  task automatic rd_regs(input logic [7:0] p, input bytes_t d);
    bus_start;
    write_byte(8'hAA, "rd_hdr_ack", 1'b0);
    write_byte(p, "rd_ptr_ack", 1'b0);
    bus_start;
    write_byte(8'hAB, "rd_addr_ack", 1'b0);
    for (int i = 0; i < d.size(); i++)
      read_byte($sformatf("rd_byte%0d", i), d[i], i != d.size() - 1);
    expect_v("sda_released", 64'd1);
    observe("sda_released", 64'(sda_t));
    bus_stop;
  endtask

  task automatic snap(input string tag, input logic [2:0] h, input logic [6:0] n,
                      input logic [37:0] r, input logic f);
    expect_v({tag, "_hs_div"}, 64'(h));
    observe({tag, "_hs_div"}, 64'(hs_div));
    expect_v({tag, "_n1"}, 64'(n));
    observe({tag, "_n1"}, 64'(n1));
    expect_v({tag, "_rfreq"}, 64'(r));
    observe({tag, "_rfreq"}, 64'(rfreq));
    expect_v({tag, "_freeze"}, 64'(f));
    observe({tag, "_freeze"}, 64'(freeze_dco));
  endtask

  initial begin
    int nf_base;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state: factory regs, SDA released, idle.
    snap("reset", 3'd0, 7'h07, FactRfreq, 1'b0);
    expect_v("reset_sda_t", 64'd1);  observe("reset_sda_t", 64'(sda_t));
    expect_v("reset_busy", 64'd0);   observe("reset_busy", 64'(busy));

    // Freeze register write, busy framing.
    bus_start;
    expect_v("busy_in_xfer", 64'd1); observe("busy_in_xfer", 64'(busy));
    write_byte(8'hAA, "frz_hdr_ack", 1'b0);
    write_byte(8'd137, "frz_ptr_ack", 1'b0);
    write_byte(8'h10, "frz_data_ack", 1'b0);
    bus_stop;
    expect_v("busy_after_stop", 64'd0); observe("busy_after_stop", 64'(busy));
    snap("freeze", 3'd0, 7'h07, FactRfreq, 1'b1);

    // Repeated-START read of the factory image.
    data = '{8'h01, 8'hC2, 8'hBC, 8'h01, 8'h1E, 8'hB8};
    rd_regs(8'd7, data);

    // New frequency words, read back, decoded outputs.
    data = '{8'hE0, 8'h03, 8'h02, 8'hB5, 8'hEA, 8'h58};
    wr_regs(8'd7, data);
    rd_regs(8'd7, data);
    snap("newwords", 3'd7, 7'h00, 38'h3_02B5_EA58, 1'b1);

    // RECALL restores factory, no new_freq pulse.
    nf_base = nf_cnt;
    data = '{8'h01};
    wr_regs(8'd135, data);
    snap("recall", 3'd0, 7'h07, FactRfreq, 1'b1);
    expect_v("recall_nf_pulses", 64'd0); observe("recall_nf_pulses", 64'(nf_cnt - nf_base));

    // NewFreq: exactly one pulse, reg135 reads 0.
    data = '{8'h40};
    wr_regs(8'd135, data);
    expect_v("newfreq_pulses", 64'd1); observe("newfreq_pulses", 64'(nf_cnt - nf_base));
    data = '{8'h00};
    rd_regs(8'd135, data);

    // Wrong address 0x54: never acknowledged, nothing written.
    saw_low = 1'b0;
    watch = 1'b1;
    bus_start;
    write_byte(8'hA8, "bad_addr_nack", 1'b1);
    write_byte(8'd7, "bad_ptr_nack", 1'b1);
    write_byte(8'hFF, "bad_data_nack", 1'b1);
    bus_stop;
    watch = 1'b0;
    expect_v("bad_sda_t_low_seen", 64'd0); observe("bad_sda_t_low_seen", 64'(saw_low));
    snap("badaddr", 3'd0, 7'h07, FactRfreq, 1'b1);

    // STOP after 4 data bits: byte dropped, next transaction fine.
    bus_start;
    write_byte(8'hAA, "abort_hdr_ack", 1'b0);
    write_byte(8'd7, "abort_ptr_ack", 1'b0);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    bus_stop;
    expect_v("abort_busy", 64'd0); observe("abort_busy", 64'(busy));
    snap("abort", 3'd0, 7'h07, FactRfreq, 1'b1);
    data = '{8'h01};
    rd_regs(8'd7, data);

    // Pointer wrap 255 -> 0 during a read, ending at reg 7.
    data = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    rd_regs(8'd255, data);

`ifdef SI570_RESP_GLITCH_FILTER_EN
    // 1-clk SCL spike before a data byte must not shift a bit.
    bus_start;
    write_byte(8'hAA, "glitch_hdr_ack", 1'b0);
    write_byte(8'd7, "glitch_ptr_ack", 1'b0);
    scl_m = 1'b1; #10; scl_m = 1'b0; #40;
    write_byte(8'hE0, "glitch_data_ack", 1'b0);
    bus_stop;
    snap("glitch", 3'd7, 7'h03, FactRfreq, 1'b1);
`endif

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
